mem_stage: RTL
==============

Name: mem_stage

Overview:
Execute→memory/writeback stage of the 16-bit processor; consumes the ALU's result and flag outputs.
- Holds the condition-code register (CCR).
- Performs load/store through a req/ack data-memory handshake, with a timeout.
- Issues registered single-cycle writeback pulses to the register file.
- Stalls the execute stage via in_ready while a memory access is outstanding.

Parameters:
DATA_W, 16, datapath / address width
RADDR_W, 3, destination register index width
TIMEOUT, 15, max cycles mem_req waits for mem_ack before abort (≥1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  execute-stage output valid
in_ready  output  1  stage can accept; combinational, =1 iff state IDLE
in_op  input  3  000 add, 001 invert, 010 load, 011 store, 100 nop, 101–111 illegal
in_result  input  DATA_W  ALU result (memory address for load/store)
in_flags  input  4  ALU flags: [0] carry, [1] zero, [2] negative, [3] overflow
in_store_data  input  DATA_W  store data
in_rd  input  RADDR_W  destination register
mem_req  output  1  memory request, registered
mem_we  output  1  1=store, 0=load; valid while mem_req
mem_addr  output  DATA_W  latched address
mem_wdata  output  DATA_W  latched store data
mem_rdata  input  DATA_W  load data, sampled in the cycle mem_ack=1
mem_ack  input  1  memory completion, single-cycle
wb_valid  output  1  writeback pulse, registered
wb_rd  output  RADDR_W  writeback register
wb_data  output  DATA_W  writeback data
ccr  output  4  condition-code register
err  output  1  one-cycle pulse: illegal op or memory timeout

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; mem_req, mem_we, wb_valid, err = 0; ccr, mem_addr, mem_wdata, wb_data, wb_rd = 0; timeout counter = 0. A reset mid-access drops mem_req on the next edge; the pending load/store is discarded with no writeback.
- States: IDLE, MEM.
- Accept: only when in_valid & in_ready at a rising edge.
- Accept, op 000 (add): next cycle wb_valid=1, wb_data=in_result, wb_rd=in_rd. ccr ← in_flags (all 4 bits).
- Accept, op 001 (invert): writeback as for add. Only ccr[1] ← in_flags[1]; ccr[0], ccr[2], ccr[3] retain their values.
- Accept, op 100 (nop): no writeback, ccr unchanged.
- Accept, ops 101–111: treated as nop; err=1 for the next cycle.
- Accept, op 010/011: latch mem_addr=in_result, mem_wdata=in_store_data, mem_we=(op==011), rd. Go to MEM; mem_req=1 from the next cycle. ccr is never updated by load/store.
- MEM:
  - mem_req, mem_we, mem_addr, mem_wdata held stable; in_ready=0; counter increments each cycle.
  - mem_ack=1 at edge, load: wb_valid=1 next cycle with wb_data=mem_rdata, wb_rd=latched rd.
  - mem_ack=1 at edge, store: no writeback.
  - On ack: mem_req=0 and state IDLE next cycle, so in_ready=1 the cycle after ack.
  - Counter reaches TIMEOUT with no ack: mem_req=0, err=1, no writeback, return to IDLE.
  - Ack in the same cycle the counter reaches TIMEOUT: the ack wins, with no err.
- mem_ack while in IDLE is ignored.
- wb_valid and err are exactly one cycle wide; they deassert the following cycle unless another event sets them.
- Latency:
  - add/invert: accept at edge T → wb_valid high in cycle T+1; back-to-back accepts allowed every cycle.
  - load: accept T → mem_req T+1 → ack sampled at T+k → wb_valid and in_ready at T+k+1. Minimum k=1, i.e. ack sampled at the first edge with mem_req high.
- No reordering: at most one memory operation is outstanding.

Test Plan:
- Reset: hold rst_n=0 two cycles, then release → ccr=0, wb_valid=0, mem_req=0, in_ready=1.
- Add: in_op=000, in_result=0x0000, in_flags=0011, in_rd=5 → next cycle wb_valid=1, wb_data=0x0000, wb_rd=5, ccr=0011. Follow immediately with add in_result=0x8000, in_flags=1100 → ccr=1100 one cycle later.
- Invert partial flags: preset ccr=1101, then in_op=001, in_result=0x0000, in_flags=0010 → ccr=1111, wb_data=0x0000.
- Load with wait states: in_op=010, in_result=0x0040, in_rd=2; memory acks 3 cycles after mem_req with mem_rdata=0xBEEF → mem_addr=0x0040 and mem_we=0 stable throughout, in_ready=0, then wb_valid=1, wb_data=0xBEEF, wb_rd=2, in_ready=1 one cycle after ack, ccr unchanged.
- Store plus timeout: store to 0x0010 with data 0x1234, ack after 1 cycle → mem_we=1, mem_wdata=0x1234, no wb_valid. Second store never acked → mem_req drops after TIMEOUT (15) cycles, err pulses once, in_ready returns.
- Illegal op and reset mid-access: in_op=110 → err=1 one cycle, no writeback, ccr unchanged. Start a load and assert rst_n=0 while mem_req=1 → mem_req=0 next cycle, no wb_valid ever asserted for that load.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundle of the execute-side input, data-memory handshake and writeback
// signals seen by mem_stage. master = the stage itself, slave = its environment.
interface mem_stage_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [DATA_W-1:0]  in_result;
  logic [3:0]         in_flags;
  logic [DATA_W-1:0]  in_store_data;
  logic [RADDR_W-1:0] in_rd;

  logic               mem_req;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_ack;

  logic               wb_valid;
  logic [RADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic [3:0]         ccr;
  logic               err;

  modport master (
    input  in_valid, in_op, in_result, in_flags, in_store_data, in_rd,
           mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_rd, wb_data, ccr, err
  );

  modport slave (
    output in_valid, in_op, in_result, in_flags, in_store_data, in_rd,
           mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           wb_valid, wb_rd, wb_data, ccr, err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory/writeback stage: owns the CCR, runs load/store over a req/ack
// handshake with timeout, and emits one-cycle writeback and error pulses.
//
// state | meaning
// IDLE  | ready for a new execute-stage result
// MEM   | load/store outstanding, mem_req held, waiting for ack or timeout
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_stage_if.master    bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_INV   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_NOP   = 3'b100;

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEM} state_e;

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [RADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic               wb_valid_q, wb_valid_d;
  logic [RADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic [3:0]         ccr_q, ccr_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pend_rd_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      ccr_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_rd_q   <= pend_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      ccr_q       <= ccr_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_rd_d   = pend_rd_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    ccr_d       = ccr_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.in_op)
            OP_ADD, OP_INV: begin
              wb_valid_d = 1'b1;
              wb_data_d  = bus.in_result;
              wb_rd_d    = bus.in_rd;
              if (bus.in_op == OP_ADD) ccr_d = bus.in_flags;
              else                     ccr_d[1] = bus.in_flags[1];
            end
            OP_LOAD, OP_STORE: begin
              mem_addr_d  = bus.in_result;
              mem_wdata_d = bus.in_store_data;
              mem_we_d    = (bus.in_op == OP_STORE);
              pend_rd_d   = bus.in_rd;
              mem_req_d   = 1'b1;
              cnt_d       = '0;
              state_d     = MEM;
            end
            OP_NOP: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      MEM: begin
        // An ack on the terminal cycle takes priority over the timeout.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!mem_we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = bus.mem_rdata;
            wb_rd_d    = pend_rd_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.ccr       = ccr_q;
  assign bus.err       = err_q;

endmodule
